spi_eeprom_slave: RTL and testbench
===================================

// Module: spi_eeprom_slave
// PURPOSE
//  SPI responder modelling the 64x8 calibration EEPROM behind SS_EEPROM. Receives the 16-bit frames
//  issued by the command dispatcher (write {2'b01,addr[5:0],data[7:0]}, read {2'b00,addr[5:0],8'hxx})
//  and returns read data as {8'h00,data} in the next selected frame. Synthesizable; also the bench EEPROM.
// PARAMETERS
//  ADDR_W       6   address bits; depth = 2**ADDR_W
//  DATA_W       8   data bits per location
//  FRAME_W      16  bits per frame (= 2+ADDR_W+DATA_W)
//  SYNC_STAGES  2   flops in SS_n/SCLK/MOSI synchronizers (>=2)
// PORTS
//  clk        in   1       system clock
//  rst_n      in   1       asynchronous reset, active-low
//  SS_n       in   1       slave select, active-low
//  SCLK       in   1       SPI clock, idle low (mode 0)
//  MOSI       in   1       master out, MSB first
//  MISO       out  1       slave out, MSB first; 0 while deselected
//  frame_done out  1       1-clk pulse after a complete FRAME_W-bit frame
//  wr_strobe  out  1       1-clk pulse when a write commits to memory
//  wr_addr    out  ADDR_W  address of last committed write (held)
//  rd_buf     out  DATA_W  data latched by last read frame (held)
//  wp         in   1       write protect (used only with EEP_WP_EN)
// BEHAVIOUR
//  - Reset: MISO=0, frame_done=0, wr_strobe=0, wr_addr=0, rd_buf=0, all memory words=0, bit_cnt=0, state=IDLE.
//  - SS_n/SCLK/MOSI pass SYNC_STAGES flops; edges detected on synchronized copies (one extra flop).
//  - Master timing contract: >= SYNC_STAGES+3 clk from SS_n fall to first SCLK rise; SCLK half period >= 4 clk.
//  - States: IDLE -> SHIFT on synced SS_n fall; SHIFT -> COMMIT when bit_cnt reaches FRAME_W on an SCLK rise;
//    COMMIT -> WAIT_DESEL (1 clk); WAIT_DESEL -> IDLE on synced SS_n rise; SHIFT -> IDLE on SS_n rise (abort).
//  - On IDLE->SHIFT: tx_shft <= {8'h00, rd_buf}, bit_cnt <= 0; MISO = tx_shft[FRAME_W-1] from this cycle.
//  - SCLK rise in SHIFT: rx_shft <= {rx_shft[FRAME_W-2:0], MOSI_sync}; bit_cnt++ (5 bits, no wrap past 16).
//  - SCLK fall in SHIFT: tx_shft <= tx_shft << 1 (zero fill). SCLK edges outside SHIFT ignored.
//  - COMMIT decode of rx_shft[15:14]: 2'b01 write mem[rx[13:8]]<=rx[7:0], wr_strobe=1, wr_addr<=rx[13:8];
//    2'b00 read rd_buf<=mem[rx[13:8]]; 2'b1x no effect. frame_done=1 in COMMIT for all opcodes.
//  - Read latency: data appears in the NEXT selected frame; intervening frames to other slaves (SS_n high,
//    SCLK toggling) do not disturb rd_buf. rd_buf holds until the next read commit.
//  - Abort: SS_n rise before 16 SCLK rises discards frame: no memory write, no rd_buf update, no frame_done.
//  - Extra SCLK rises after bit 16 (WAIT_DESEL) ignored; MISO shifts zeros.
//  - Simultaneous synced SS_n rise and 16th SCLK rise: frame counts as complete (COMMIT wins).
//  - Reset mid-frame: frame discarded, all state/outputs to reset values, memory cleared.
//  - MISO forced 0 whenever synced SS_n is high.
// CONFIGURATION
//  EEP_WP_EN defined: wp input honoured; write frame with wp=1 (sampled in COMMIT) leaves memory and wr_addr
//    unchanged, wr_strobe stays 0, frame_done still pulses; reads unaffected.
//  EEP_WP_EN undefined: wp ignored (left unconnected internally); all write frames commit.
// TESTING
//  - Reset, frame 16'h4A5C (write addr 0x0A data 0x5C) -> wr_strobe pulse, wr_addr=0x0A, mem[0x0A]=0x5C.
//  - Read 16'h0A00, dummy frame with SS_n high, frame 16'h0000 selected -> MISO shifts 16'h005C; rd_buf=0x5C.
//  - Read of never-written addr 0x3F after reset -> next frame returns 16'h0000.
//  - Write 16'h4133 aborted by SS_n rise after 9 SCLK rises -> no wr_strobe/frame_done, mem[0x01] stays 0x00.
//  - rst_n asserted after 8 bits of write frame -> rd_buf=0, memory all 0, next full frame decodes normally.
//  - EEP_WP_EN, wp=1, write 16'h7FFF -> frame_done pulse, no wr_strobe, later read of 0x3F returns 0x00.

Source files
------------

// File: rtl/spi_eeprom_slave.sv
// spi_eeprom_slave: SPI mode-0 responder modelling a 2**ADDR_W x DATA_W
// calibration EEPROM. Frames are {op[1:0], addr, data}; op 01 writes, op 00
// reads (data returned as {'0, data} in the next selected frame).
// Optional feature macro: EEP_WP_EN (honour the wp input on write frames).
module spi_eeprom_slave #(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 8,
  parameter int FRAME_W     = 2 + ADDR_W + DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              SCLK,
  input  logic              MOSI,
  output logic              MISO,
  output logic              frame_done,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] rd_buf,
  input  logic              wp
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = $clog2(FRAME_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_COMMIT,
    S_WAIT_DESEL
  } state_t;

  state_t r_state, w_next;

  logic [SYNC_STAGES-1:0] r_ss_sync, r_sclk_sync, r_mosi_sync;
  logic                   r_ss_d, r_sclk_d;
  logic                   w_ss, w_sclk, w_mosi;
  logic                   w_ss_fall, w_sclk_rise, w_sclk_fall;
  logic [FRAME_W-1:0]     r_rx, r_tx;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [DATA_W-1:0]      r_mem [DEPTH];
  logic [ADDR_W-1:0]      r_wr_addr;
  logic [DATA_W-1:0]      r_rd_buf;
  logic [1:0]             w_op;
  logic [ADDR_W-1:0]      w_addr;
  logic [DATA_W-1:0]      w_data;
  logic                   w_wp_block;
  logic                   w_wr, w_rd, w_frame_done;

`ifdef EEP_WP_EN
  assign w_wp_block = wp;
`else
  logic w_unused_wp;
  assign w_unused_wp = wp;
  assign w_wp_block  = 1'b0;
`endif

  assign w_ss   = r_ss_sync[SYNC_STAGES-1];
  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  assign w_ss_fall   = r_ss_d & ~w_ss;
  assign w_sclk_rise = ~r_sclk_d & w_sclk;
  assign w_sclk_fall = r_sclk_d & ~w_sclk;

  assign w_op   = r_rx[FRAME_W-1 -: 2];
  assign w_addr = r_rx[DATA_W +: ADDR_W];
  assign w_data = r_rx[DATA_W-1:0];

  assign MISO       = ~w_ss & r_tx[FRAME_W-1];
  assign frame_done = w_frame_done;
  assign wr_strobe  = w_wr;
  assign wr_addr    = r_wr_addr;
  assign rd_buf     = r_rd_buf;

  // Input synchronizers plus one delay flop for edge detection; SS_n resets deselected
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ss_sync   <= '1;
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_ss_d      <= 1'b1;
      r_sclk_d    <= 1'b0;
    end else begin
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SS_n};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
      r_ss_d      <= w_ss;
      r_sclk_d    <= w_sclk;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state and commit strobes; the 16th SCLK rise takes priority over a
  // simultaneous deselect, and WAIT_DESEL leaves on the SS_n level so that
  // case still returns to IDLE.
  always_comb begin
    w_next       = r_state;
    w_frame_done = 1'b0;
    w_wr         = 1'b0;
    w_rd         = 1'b0;
    unique case (r_state)
      S_IDLE:       if (w_ss_fall) w_next = S_SHIFT;
      S_SHIFT: begin
        if (w_sclk_rise && (r_bit_cnt == CNT_W'(FRAME_W - 1))) w_next = S_COMMIT;
        else if (w_ss)                                          w_next = S_IDLE;
      end
      S_COMMIT: begin
        w_frame_done = 1'b1;
        w_wr         = (w_op == 2'b01) && !w_wp_block;
        w_rd         = (w_op == 2'b00);
        w_next       = S_WAIT_DESEL;
      end
      S_WAIT_DESEL: if (w_ss) w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  // Shift registers and saturating bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx      <= '0;
      r_tx      <= '0;
      r_bit_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_ss_fall) begin
        r_tx      <= FRAME_W'(r_rd_buf);
        r_bit_cnt <= '0;
      end
    end else if (r_state == S_SHIFT && w_sclk_rise) begin
      r_rx <= {r_rx[FRAME_W-2:0], w_mosi};
      if (r_bit_cnt != CNT_W'(FRAME_W)) r_bit_cnt <= r_bit_cnt + 1'b1;
    end else if (w_sclk_fall) begin
      r_tx <= {r_tx[FRAME_W-2:0], 1'b0};
    end
  end

  // Memory array, write-address and read-buffer updates on commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_addr <= '0;
      r_rd_buf  <= '0;
    end else begin
      if (w_wr) begin
        r_mem[w_addr] <= w_data;
        r_wr_addr     <= w_addr;
      end
      if (w_rd) r_rd_buf <= r_mem[w_addr];
    end
  end

endmodule

// File: tb/tb_spi_eeprom_slave.sv
// Table-driven bench for spi_eeprom_slave with hand-written corner sequences.
module tb_spi_eeprom_slave;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       SS_n = 1'b1;
  logic       SCLK = 1'b0;
  logic       MOSI = 1'b0;
  logic       wp = 1'b0;
  logic       MISO, frame_done, wr_strobe;
  logic [5:0] wr_addr;
  logic [7:0] rd_buf;

  int checks = 0;
  int errors = 0;
  int fd_tot = 0;
  int ws_tot = 0;

  localparam int HALF = 8;

  spi_eeprom_slave #(.ADDR_W(6), .DATA_W(8), .FRAME_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .frame_done(frame_done), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .rd_buf(rd_buf), .wp(wp)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge
  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_tot++;
    if (wr_strobe === 1'b1)  ws_tot++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One master frame: nbits SCLK pulses, MISO captured before each rise.
  // ss_at_last raises SS_n together with the final SCLK rise.
  task automatic spi_frame(input logic [15:0] f, input bit sel, input int nbits,
                           input bit ss_at_last, output logic [15:0] cap,
                           output int fd, output int ws);
    int fd0, ws0;
    fd0 = fd_tot;
    ws0 = ws_tot;
    cap = '0;
    SS_n = ~sel;
    wait_clk(HALF);
    for (int i = 0; i < nbits; i++) begin
      MOSI = f[15-i];
      wait_clk(HALF);
      cap[15-i] = MISO;
      SCLK = 1'b1;
      if (ss_at_last && i == nbits - 1) SS_n = 1'b1;
      wait_clk(HALF);
      SCLK = 1'b0;
    end
    wait_clk(HALF);
    SS_n = 1'b1;
    wait_clk(HALF);
    fd = fd_tot - fd0;
    ws = ws_tot - ws0;
  endtask

  typedef struct {
    logic [15:0] frame;
    bit          sel;
    logic [15:0] exp_miso;
    int          exp_fd;
    int          exp_ws;
    logic [5:0]  exp_wa;
    logic [7:0]  exp_rb;
  } vec_t;

  vec_t        vecs[12];
  logic [15:0] cap;
  int          fd, ws;

  initial begin
    vecs[0]  = '{16'h4A5C, 1'b1, 16'h0000, 1, 1, 6'h0A, 8'h00};
    vecs[1]  = '{16'h0A00, 1'b1, 16'h0000, 1, 0, 6'h0A, 8'h5C};
    vecs[2]  = '{16'h0000, 1'b0, 16'h0000, 0, 0, 6'h0A, 8'h5C};
    vecs[3]  = '{16'h3F00, 1'b1, 16'h005C, 1, 0, 6'h0A, 8'h00};
    vecs[4]  = '{16'h0000, 1'b1, 16'h0000, 1, 0, 6'h0A, 8'h00};
    vecs[5]  = '{16'h41A7, 1'b1, 16'h0000, 1, 1, 6'h01, 8'h00};
    vecs[6]  = '{16'h0100, 1'b1, 16'h0000, 1, 0, 6'h01, 8'hA7};
    vecs[7]  = '{16'hC1FF, 1'b1, 16'h00A7, 1, 0, 6'h01, 8'hA7};
    vecs[8]  = '{16'h8A11, 1'b1, 16'h00A7, 1, 0, 6'h01, 8'hA7};
    vecs[9]  = '{16'h0100, 1'b1, 16'h00A7, 1, 0, 6'h01, 8'hA7};
    vecs[10] = '{16'h0A00, 1'b1, 16'h00A7, 1, 0, 6'h01, 8'h5C};
    vecs[11] = '{16'h0000, 1'b1, 16'h005C, 1, 0, 6'h01, 8'h00};

    // Reset state
    wait_clk(3);
    chk("rst_miso", 16'(MISO), 16'h0);
    chk("rst_frame_done", 16'(frame_done), 16'h0);
    chk("rst_wr_strobe", 16'(wr_strobe), 16'h0);
    chk("rst_wr_addr", 16'(wr_addr), 16'h0);
    chk("rst_rd_buf", 16'(rd_buf), 16'h0);
    rst_n = 1'b1;
    wait_clk(4);

    for (int i = 0; i < 12; i++) begin
      spi_frame(vecs[i].frame, vecs[i].sel, 16, 1'b0, cap, fd, ws);
      chk($sformatf("v%0d_miso", i), cap, vecs[i].exp_miso);
      chk($sformatf("v%0d_frame_done", i), 16'(fd), 16'(vecs[i].exp_fd));
      chk($sformatf("v%0d_wr_strobe", i), 16'(ws), 16'(vecs[i].exp_ws));
      chk($sformatf("v%0d_wr_addr", i), 16'(wr_addr), 16'(vecs[i].exp_wa));
      chk($sformatf("v%0d_rd_buf", i), 16'(rd_buf), 16'(vecs[i].exp_rb));
    end

    // Deselect coinciding with the 16th SCLK rise still commits
    spi_frame(16'h4255, 1'b1, 16, 1'b1, cap, fd, ws);
    chk("simul_frame_done", 16'(fd), 16'd1);
    chk("simul_wr_strobe", 16'(ws), 16'd1);
    chk("simul_wr_addr", 16'(wr_addr), 16'h02);
    spi_frame(16'h0200, 1'b1, 16, 1'b0, cap, fd, ws);
    chk("simul_rd_buf", 16'(rd_buf), 16'h55);

    // Reset in the middle of a write frame
    SS_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 8; i++) begin
      MOSI = (i % 2 == 0);
      wait_clk(HALF);
      SCLK = 1'b1;
      wait_clk(HALF);
      SCLK = 1'b0;
    end
    rst_n = 1'b0;
    wait_clk(2);
    chk("midrst_miso", 16'(MISO), 16'h0);
    chk("midrst_rd_buf", 16'(rd_buf), 16'h0);
    chk("midrst_wr_addr", 16'(wr_addr), 16'h0);
    SS_n = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(4);
    spi_frame(16'h0A00, 1'b1, 16, 1'b0, cap, fd, ws);
    chk("midrst_fd_after", 16'(fd), 16'd1);
    chk("midrst_mem0A", 16'(rd_buf), 16'h00);
    spi_frame(16'h0200, 1'b1, 16, 1'b0, cap, fd, ws);
    chk("midrst_mem02", 16'(rd_buf), 16'h00);

    // Abort after 9 SCLK rises discards the write
    spi_frame(16'h4133, 1'b1, 9, 1'b0, cap, fd, ws);
    chk("abort_frame_done", 16'(fd), 16'd0);
    chk("abort_wr_strobe", 16'(ws), 16'd0);
    chk("abort_wr_addr", 16'(wr_addr), 16'h00);
    spi_frame(16'h0100, 1'b1, 16, 1'b0, cap, fd, ws);
    chk("abort_mem01", 16'(rd_buf), 16'h00);
    spi_frame(16'h4133, 1'b1, 16, 1'b0, cap, fd, ws);
    chk("after_abort_wr_strobe", 16'(ws), 16'd1);
    chk("after_abort_wr_addr", 16'(wr_addr), 16'h01);
    spi_frame(16'h0100, 1'b1, 16, 1'b0, cap, fd, ws);
    chk("after_abort_miso", cap, 16'h0000);
    chk("after_abort_rd_buf", 16'(rd_buf), 16'h33);

    // Write with wp asserted
    wp = 1'b1;
    spi_frame(16'h7FFF, 1'b1, 16, 1'b0, cap, fd, ws);
    chk("wp_frame_done", 16'(fd), 16'd1);
`ifdef EEP_WP_EN
    chk("wp_wr_strobe", 16'(ws), 16'd0);
    chk("wp_wr_addr", 16'(wr_addr), 16'h01);
`else
    chk("wp_wr_strobe", 16'(ws), 16'd1);
    chk("wp_wr_addr", 16'(wr_addr), 16'h3F);
`endif
    spi_frame(16'h3F00, 1'b1, 16, 1'b0, cap, fd, ws);
    chk("wp_read_miso", cap, 16'h0033);
`ifdef EEP_WP_EN
    chk("wp_mem3F", 16'(rd_buf), 16'h00);
`else
    chk("wp_mem3F", 16'(rd_buf), 16'hFF);
`endif
    wp = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
